// File: rtl/irig_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// irig_pkg : IRIG-B frame layout, symbol and FSM encodings shared by the
//            encoder and the receiver/parser.          Revision: 1.0
// ---------------------------------------------------------------------------
package irig_pkg;

    localparam logic [6:0] LAST_BIT_IDX = 7'd99;

    // Position identifiers: Pr, then P1..P9, then P0 closing the frame
    localparam logic [6:0] POS_PR = 7'd0;
    localparam logic [6:0] POS_P1 = 7'd9;
    localparam logic [6:0] POS_P2 = 7'd19;
    localparam logic [6:0] POS_P3 = 7'd29;
    localparam logic [6:0] POS_P4 = 7'd39;
    localparam logic [6:0] POS_P5 = 7'd49;
    localparam logic [6:0] POS_P6 = 7'd59;
    localparam logic [6:0] POS_P7 = 7'd69;
    localparam logic [6:0] POS_P8 = 7'd79;
    localparam logic [6:0] POS_P9 = 7'd89;
    localparam logic [6:0] POS_P0 = 7'd99;

    localparam int POS_SEC_UNITS  = 1;
    localparam int POS_SEC_TENS   = 6;
    localparam int POS_MIN_UNITS  = 10;
    localparam int POS_MIN_TENS   = 15;
    localparam int POS_HOUR_UNITS = 20;
    localparam int POS_HOUR_TENS  = 25;
    localparam int POS_DAY_UNITS  = 30;
    localparam int POS_DAY_TENS   = 35;
    localparam int POS_DAY_HUNDS  = 40;

    typedef enum logic [1:0] {
        SYM_ZERO = 2'd0,
        SYM_ONE  = 2'd1,
        SYM_MARK = 2'd2
    } irig_sym_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_HIGH = 2'b10,
        ST_LOW  = 2'b11
    } irig_state_t;

    typedef struct packed {
        logic [9:0] day;
        logic [5:0] hour;
        logic [6:0] min;
        logic [6:0] sec;
    } irig_time_t;

    function automatic logic is_marker(input logic [6:0] idx);
        return (idx == POS_PR) || (idx == POS_P1) || (idx == POS_P2) ||
               (idx == POS_P3) || (idx == POS_P4) || (idx == POS_P5) ||
               (idx == POS_P6) || (idx == POS_P7) || (idx == POS_P8) ||
               (idx == POS_P9) || (idx == POS_P0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/irig_bit_mapper.sv
`default_nettype none
// ---------------------------------------------------------------------------
// irig_bit_mapper : combinational map of (bit index, frame time) to symbol.
//                                                     Revision: 1.0
// ---------------------------------------------------------------------------
module irig_bit_mapper
    import irig_pkg::*;
(
    input  logic [6:0] bit_idx_i,
    input  irig_time_t frame_i,
    output irig_sym_t  sym_o
);

    // Padded to 128 so any 7-bit index is in range; unused slots stay zero
    logic [127:0] w_data_bits;

    always_comb begin
        w_data_bits = '0;
        w_data_bits[POS_SEC_UNITS  +: 4] = frame_i.sec[3:0];
        w_data_bits[POS_SEC_TENS   +: 3] = frame_i.sec[6:4];
        w_data_bits[POS_MIN_UNITS  +: 4] = frame_i.min[3:0];
        w_data_bits[POS_MIN_TENS   +: 3] = frame_i.min[6:4];
        w_data_bits[POS_HOUR_UNITS +: 4] = frame_i.hour[3:0];
        w_data_bits[POS_HOUR_TENS  +: 2] = frame_i.hour[5:4];
        w_data_bits[POS_DAY_UNITS  +: 4] = frame_i.day[3:0];
        w_data_bits[POS_DAY_TENS   +: 4] = frame_i.day[7:4];
        w_data_bits[POS_DAY_HUNDS  +: 2] = frame_i.day[9:8];

        sym_o = SYM_ZERO;
        if (is_marker(bit_idx_i)) begin
            sym_o = SYM_MARK;
        end else if (w_data_bits[bit_idx_i]) begin
            sym_o = SYM_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/irig_b_encoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// irig_b_encoder : IRIG-B DC-level-shift frame generator timed by ms_tick.
//                                                     Revision: 1.0
// ---------------------------------------------------------------------------
module irig_b_encoder
    import irig_pkg::*;
#(
    parameter int MS_PER_BIT = 10,
    parameter int W_ZERO     = 2,
    parameter int W_ONE      = 5,
    parameter int W_MARK     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       ms_tick,
    input  logic       enable,
    input  logic       time_load,
    input  logic [6:0] sec_bcd,
    input  logic [6:0] min_bcd,
    input  logic [5:0] hour_bcd,
    input  logic [9:0] day_bcd,
    output logic       irig_out,
    output logic       frame_start,
    output logic [6:0] bit_idx,
    output logic [1:0] state_out
);

    localparam int CNT_W = $clog2(MS_PER_BIT + 1);

    irig_state_t      state_q;
    logic             irig_out_q;
    logic             frame_start_q;
    logic [6:0]       bit_idx_q;
    logic [CNT_W-1:0] ms_cnt_q;
    irig_time_t       shadow_q;
    irig_time_t       frame_q;

    irig_time_t       w_time_in;
    irig_sym_t        w_sym;
    logic [CNT_W-1:0] w_width;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_time_in = {day_bcd, hour_bcd, min_bcd, sec_bcd};
    assign w_cnt_inc = ms_cnt_q + CNT_W'(1);

    irig_bit_mapper u_bit_mapper (
        .bit_idx_i (bit_idx_q),
        .frame_i   (frame_q),
        .sym_o     (w_sym)
    );

    always_comb begin
        w_width = CNT_W'(W_ZERO);
        case (w_sym)
            SYM_ONE:  w_width = CNT_W'(W_ONE);
            SYM_MARK: w_width = CNT_W'(W_MARK);
            default:  w_width = CNT_W'(W_ZERO);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            irig_out_q    <= 1'b0;
            frame_start_q <= 1'b0;
            bit_idx_q     <= '0;
            ms_cnt_q      <= '0;
            shadow_q      <= '0;
            frame_q       <= '0;
        end else if (ce) begin
            frame_start_q <= 1'b0;
            if (time_load) begin
                shadow_q <= w_time_in;
            end

            case (state_q)
                ST_IDLE: begin
                    irig_out_q <= 1'b0;
                    if (ms_tick && enable) begin
                        state_q       <= ST_LOAD;
                        frame_start_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    // A strobe in this very cycle must reach the frame now
                    frame_q    <= time_load ? w_time_in : shadow_q;
                    bit_idx_q  <= '0;
                    ms_cnt_q   <= '0;
                    state_q    <= ST_HIGH;
                    irig_out_q <= 1'b1;
                end
                ST_HIGH: begin
                    if (ms_tick) begin
                        ms_cnt_q <= w_cnt_inc;
                        if (w_cnt_inc >= w_width) begin
                            state_q    <= ST_LOW;
                            irig_out_q <= 1'b0;
                        end
                    end
                end
                ST_LOW: begin
                    if (ms_tick) begin
                        if (w_cnt_inc >= CNT_W'(MS_PER_BIT)) begin
                            ms_cnt_q <= '0;
                            if (bit_idx_q != LAST_BIT_IDX) begin
                                bit_idx_q  <= bit_idx_q + 7'd1;
                                state_q    <= ST_HIGH;
                                irig_out_q <= 1'b1;
                            end else if (enable) begin
                                state_q       <= ST_LOAD;
                                frame_start_q <= 1'b1;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            ms_cnt_q <= w_cnt_inc;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign irig_out    = irig_out_q;
    assign frame_start = frame_start_q;
    assign bit_idx     = bit_idx_q;
    assign state_out   = state_q;

endmodule
`default_nettype wire
